// File: rtl/mips_fetch_unit.sv
// Instruction-fetch stage: owns the PC, captures instruction words into IF/ID,
// and handles stall, redirect-with-squash, halt detection and fetch counting.
//
// state | meaning
// BOOT  | first cycle after reset, nothing captured, pc held
// RUN   | normal fetch, redirects and stalls honoured
// HALT  | HALT_WORD captured, fetch frozen until reset
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h00000000,
    parameter logic [31:0] HALT_WORD = 32'h0000000C,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [31:0]      imem_addr,
    input  logic [31:0]      imem_data,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [15:0]      branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_target,
    input  logic             jr,
    input  logic [31:0]      jr_addr,
    output logic [31:0]      id_instr,
    output logic [31:0]      id_pc,
    output logic             id_valid,
    output logic             halted,
    output logic             misaligned,
    output logic [CNT_W-1:0] fetch_count
);

    typedef enum logic [1:0] {BOOT, RUN, HALT} state_t;

    state_t      state, state_next;
    logic [31:0] pc;
    logic [31:0] id_pc_plus4;
    logic [31:0] branch_disp;
    logic [31:0] redirect_target;
    logic        redirect;
    logic        capture;
    logic        halt_hit;

    assign imem_addr = pc;

    // Redirects come from the instruction in ID, so they only count while it is live.
    assign redirect = (state == RUN) && id_valid && (jr || jump || branch_taken);
    assign capture  = (state == RUN) && !redirect && !stall;
    assign halt_hit = capture && (imem_data == HALT_WORD);

    assign id_pc_plus4 = id_pc + 32'd4;
    assign branch_disp = {{14{branch_offset[15]}}, branch_offset, 2'b00};

    always_comb begin
        redirect_target = id_pc_plus4 + branch_disp;
        if (jr) begin
            redirect_target = {jr_addr[31:2], 2'b00};
        end else if (jump) begin
            redirect_target = {id_pc_plus4[31:28], jump_target, 2'b00};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= BOOT;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            BOOT:    state_next = RUN;
            RUN:     if (halt_hit) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = BOOT;
        endcase
    end

    always_comb begin
        halted = (state == HALT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            id_instr    <= 32'h0;
            id_pc       <= 32'h0;
            id_valid    <= 1'b0;
            misaligned  <= 1'b0;
            fetch_count <= '0;
        end else if (redirect) begin
            pc       <= redirect_target;
            id_instr <= 32'h0;
            id_valid <= 1'b0;
            if (jr && (jr_addr[1:0] != 2'b00)) begin
                misaligned <= 1'b1;
            end
        end else if (capture) begin
            id_instr <= imem_data;
            id_pc    <= pc;
            id_valid <= 1'b1;
            pc       <= halt_hit ? pc : pc + 32'd4;
            if (fetch_count != '1) begin
                fetch_count <= fetch_count + CNT_W'(1);
            end
        end else if (state == HALT) begin
            id_valid <= 1'b0;
        end
    end

endmodule
